// File: rtl/rp_drain_if.sv
// Boundary signal bundle between a reconfigurable partition and its drain controller.
// The controller takes the slave view; the partition/static-side glue takes the master view.
interface rp_drain_if #(
   parameter int NUM_ETH = 4,
   parameter int NUM_AXI = 3
);
   logic               shutdown_req;
   logic               shutdown_ack;
   logic               active;
   logic               irq;
   logic               decouple;
   logic               timeout_flag;
   logic [NUM_ETH-1:0] eth_tvalid;
   logic [NUM_ETH-1:0] eth_tready;
   logic [NUM_ETH-1:0] eth_tlast;
   logic [NUM_ETH-1:0] eth_tx_en;
   logic [NUM_AXI-1:0] axi_req_hs;
   logic [NUM_AXI-1:0] axi_rsp_hs;
   logic [NUM_AXI-1:0] axi_req_en;

   modport slave (
      input  shutdown_req, eth_tvalid, eth_tready, eth_tlast, axi_req_hs, axi_rsp_hs,
      output shutdown_ack, active, irq, decouple, timeout_flag, eth_tx_en, axi_req_en
   );

   modport master (
      output shutdown_req, eth_tvalid, eth_tready, eth_tlast, axi_req_hs, axi_rsp_hs,
      input  shutdown_ack, active, irq, decouple, timeout_flag, eth_tx_en, axi_req_en
   );
endinterface

// File: rtl/rp_drain_ctrl.sv
// Shutdown/drain controller for a reconfigurable partition: gates new frames and AXI requests,
// waits for in-flight traffic, then acks and decouples. Optional drain timeout: RP_DRAIN_TIMEOUT_EN.
module rp_drain_ctrl #(
   parameter int NUM_ETH   = 4,
   parameter int NUM_AXI   = 3,
   parameter int CNT_W     = 6,
   parameter int TIMEOUT_W = 16
) (
   input logic       clk,
   input logic       rst_n,
   rp_drain_if.slave bus
);

   typedef enum logic [1:0] {
      ST_ACTIVE,
      ST_DRAIN,
      ST_HALTED
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t             r_state;
   state_t             w_next;
   logic [NUM_ETH-1:0] r_in_frame;
   logic [CNT_W-1:0]   r_outst [NUM_AXI];
   logic               r_irq;
   logic [NUM_ETH-1:0] w_beat;
   logic               w_drained;
   logic               w_timeout;
   logic               w_active;
   logic [NUM_AXI-1:0] w_req_en;

   assign w_beat = bus.eth_tvalid & bus.eth_tready;

   // A non-last beat opens a frame, a last beat closes it; single-beat frames never open one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_frame <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         r_in_frame <= (r_in_frame & ~w_beat) | (w_beat & ~bus.eth_tlast);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: this is a small array of control counters, not a RAM, so resetting every entry is intended.
         for (int j = 0; j < NUM_AXI; j++) r_outst[j] <= '0;
      end else begin
         for (int j = 0; j < NUM_AXI; j++) begin
            if (bus.axi_req_hs[j] && !bus.axi_rsp_hs[j] && (r_outst[j] != CNT_MAX))
               r_outst[j] <= r_outst[j] + 1'b1;
            else if (bus.axi_rsp_hs[j] && !bus.axi_req_hs[j] && (r_outst[j] != '0))
               r_outst[j] <= r_outst[j] - 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the block can leave a variable unassigned (no latches).
      w_drained = (r_in_frame == '0);
      for (int j = 0; j < NUM_AXI; j++) begin
         if (r_outst[j] != '0) w_drained = 1'b0;
      end
   end

`ifdef RP_DRAIN_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] r_tcnt;
   logic                 r_tflag;

   // Counts cycles spent in DRAIN; reads zero on the first DRAIN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_tcnt <= '0;
      else if (r_state != ST_DRAIN) r_tcnt <= '0;
      else                        r_tcnt <= r_tcnt + 1'b1;
   end

   assign w_timeout = (r_state == ST_DRAIN) && (r_tcnt == '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                       r_tflag <= 1'b0;
      else if (w_next == ST_ACTIVE)                     r_tflag <= 1'b0;
      else if (w_timeout && !w_drained && bus.shutdown_req) r_tflag <= 1'b1;
   end

   assign bus.timeout_flag = r_tflag;
`else
   wire [TIMEOUT_W-1:0] w_unused_timeout = '0;

   assign w_timeout        = 1'b0;
   assign bus.timeout_flag = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_ACTIVE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_ACTIVE: if (bus.shutdown_req) w_next = ST_DRAIN;
         ST_DRAIN: begin
            if (!bus.shutdown_req)         w_next = ST_ACTIVE;
            else if (w_drained || w_timeout) w_next = ST_HALTED;
         end
         ST_HALTED: if (!bus.shutdown_req) w_next = ST_ACTIVE;
         default:   w_next = ST_ACTIVE;
      endcase
   end

   // irq lines up with the first cycle of shutdown_ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_irq <= 1'b0;
      else        r_irq <= (w_next == ST_HALTED) && (r_state != ST_HALTED);
   end

   assign w_active = (r_state == ST_ACTIVE);

   always_comb begin
      w_req_en = '0;
      for (int j = 0; j < NUM_AXI; j++) begin
         w_req_en[j] = w_active && (r_outst[j] != CNT_MAX);
      end
   end

   assign bus.active       = w_active;
   assign bus.shutdown_ack = (r_state == ST_HALTED);
   assign bus.decouple     = (r_state == ST_HALTED);
   assign bus.irq          = r_irq;
   assign bus.eth_tx_en    = {NUM_ETH{w_active}} | r_in_frame;
   assign bus.axi_req_en   = w_req_en;

endmodule

// File: tb/tb_rp_drain_ctrl.sv
// Scoreboard bench for rp_drain_ctrl: directed drain scenarios followed by random traffic,
// all compared cycle by cycle against a behavioural model of the drain rules.
module tb_rp_drain_ctrl;

   localparam int NUM_ETH   = 4;
   localparam int NUM_AXI   = 3;
   localparam int CNT_W     = 3;
   localparam int TIMEOUT_W = 4;
   localparam int CNT_MAX_I = (1 << CNT_W) - 1;
   localparam int T_MAX_I   = (1 << TIMEOUT_W) - 1;
`ifdef RP_DRAIN_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int P_RUN  = 0;
   localparam int P_WAIT = 1;
   localparam int P_HALT = 2;

   typedef struct packed {
      logic               active;
      logic               ack;
      logic               decouple;
      logic               irq;
      logic               tflag;
      logic [NUM_ETH-1:0] tx_en;
      logic [NUM_AXI-1:0] req_en;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_total = 0;
   int   n_bad   = 0;
   exp_t exp_q[$];

   // behavioural model
   int m_phase;
   bit m_frame [NUM_ETH];
   int m_cnt   [NUM_AXI];
   int m_wait_cycles;
   bit m_irq;
   bit m_tflag;

   rp_drain_if #(.NUM_ETH(NUM_ETH), .NUM_AXI(NUM_AXI)) bus ();

   rp_drain_ctrl #(
      .NUM_ETH(NUM_ETH), .NUM_AXI(NUM_AXI), .CNT_W(CNT_W), .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_phase = P_RUN;
      m_wait_cycles = 0;
      m_irq = 0;
      m_tflag = 0;
      foreach (m_frame[i]) m_frame[i] = 0;
      foreach (m_cnt[j]) m_cnt[j] = 0;
   endfunction

   function automatic bit m_txen(input int i);
      return (m_phase == P_RUN) || m_frame[i];
   endfunction

   // Advance the model by one clock using the inputs held during the cycle just ended.
   function automatic void model_step();
      bit quiet = 1;
      bit forced = 0;
      int nxt = m_phase;
      foreach (m_frame[i]) if (m_frame[i]) quiet = 0;
      foreach (m_cnt[j]) if (m_cnt[j] != 0) quiet = 0;
      if (m_phase == P_RUN) begin
         if (bus.shutdown_req) nxt = P_WAIT;
      end else if (m_phase == P_WAIT) begin
         if (!bus.shutdown_req) nxt = P_RUN;
         else if (quiet) nxt = P_HALT;
         else if (TO_EN && m_wait_cycles == T_MAX_I) begin
            nxt = P_HALT;
            forced = 1;
         end
      end else begin
         if (!bus.shutdown_req) nxt = P_RUN;
      end
      m_irq = (nxt == P_HALT) && (m_phase != P_HALT);
      if (nxt == P_RUN) m_tflag = 0;
      else if (forced) m_tflag = 1;
      m_wait_cycles = (m_phase == P_WAIT) ? m_wait_cycles + 1 : 0;
      for (int i = 0; i < NUM_ETH; i++)
         if (bus.eth_tvalid[i] && bus.eth_tready[i]) m_frame[i] = !bus.eth_tlast[i];
      for (int j = 0; j < NUM_AXI; j++) begin
         if (bus.axi_req_hs[j] && !bus.axi_rsp_hs[j]) m_cnt[j]++;
         else if (bus.axi_rsp_hs[j] && !bus.axi_req_hs[j] && m_cnt[j] > 0) m_cnt[j]--;
      end
      m_phase = nxt;
   endfunction

   function automatic exp_t expected();
      exp_t e;
      e.active   = (m_phase == P_RUN);
      e.ack      = (m_phase == P_HALT);
      e.decouple = (m_phase == P_HALT);
      e.irq      = m_irq;
      e.tflag    = m_tflag;
      for (int i = 0; i < NUM_ETH; i++) e.tx_en[i] = m_txen(i);
      for (int j = 0; j < NUM_AXI; j++) e.req_en[j] = (m_phase == P_RUN) && (m_cnt[j] != CNT_MAX_I);
      return e;
   endfunction

   // One clock: model follows the edge, then the expectation for this cycle is queued.
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      exp_q.push_back(expected());
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      exp_q.push_back(expected());
   endtask

   task automatic wait_ack(input int limit, output int lat);
      lat = -1;
      for (int n = 1; n <= limit; n++) begin
         tick();
         if (bus.shutdown_ack === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic idle_inputs();
      bus.eth_tvalid = '0;
      bus.eth_tready = '0;
      bus.eth_tlast  = '0;
      bus.axi_req_hs = '0;
      bus.axi_rsp_hs = '0;
   endtask

   // monitor: compares every cycle the DUT presents against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("active",       32'(bus.active),       32'(e.active));
            check("shutdown_ack", 32'(bus.shutdown_ack), 32'(e.ack));
            check("decouple",     32'(bus.decouple),     32'(e.decouple));
            check("irq",          32'(bus.irq),          32'(e.irq));
            check("timeout_flag", 32'(bus.timeout_flag), 32'(e.tflag));
            check("eth_tx_en",    32'(bus.eth_tx_en),    32'(e.tx_en));
            check("axi_req_en",   32'(bus.axi_req_en),   32'(e.req_en));
         end
      end
   end

   initial begin
      int lat;
      rst_n = 1'b0;
      bus.shutdown_req = 1'b0;
      idle_inputs();
      model_reset();
      repeat (3) tick();
      rst_n = 1'b1;

      // idle shutdown: ack and irq two edges after the request
      repeat (8) tick();
      bus.shutdown_req = 1'b1;
      wait_ack(10, lat);
      check("idle_lat", 32'(lat), 32'd2);
      check("idle_irq", 32'(bus.irq), 32'd1);
      check("idle_tx_en", 32'(bus.eth_tx_en), 32'd0);
      check("idle_req_en", 32'(bus.axi_req_en), 32'd0);
      bus.shutdown_req = 1'b0;
      repeat (2) tick();

      // frame completion on channel 2: three beats before the request, five after
      bus.eth_tvalid[2] = 1'b1;
      bus.eth_tready[2] = 1'b1;
      repeat (3) tick();
      bus.eth_tvalid[2] = 1'b0;
      bus.shutdown_req = 1'b1;
      tick();
      check("frame_tx_en", 32'(bus.eth_tx_en), 32'h4);
      bus.eth_tvalid[2] = 1'b1;
      repeat (4) tick();
      bus.eth_tlast[2] = 1'b1;
      tick();
      idle_inputs();
      wait_ack(10, lat);
      check("frame_lat", 32'(lat + 1), 32'd2);  // +1 for the tlast tick
      bus.shutdown_req = 1'b0;
      repeat (2) tick();

      // outstanding drain on master 1, including one simultaneous req/rsp cycle
      bus.axi_req_hs[1] = 1'b1;
      repeat (5) tick();
      bus.axi_rsp_hs[1] = 1'b1;
      tick();
      idle_inputs();
      bus.shutdown_req = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         bus.axi_rsp_hs[1] = 1'b1;
         tick();
         bus.axi_rsp_hs[1] = 1'b0;
         if (k < 5) begin
            repeat (3) tick();
            check("outst_no_ack", 32'(bus.shutdown_ack), 32'd0);
         end
      end
      wait_ack(10, lat);
      check("outst_lat", 32'(lat + 1), 32'd2);  // +1 for the fifth response tick
      bus.shutdown_req = 1'b0;
      repeat (2) tick();

      // abort during DRAIN, then resume from HALTED
      bus.axi_req_hs[0] = 1'b1;
      tick();
      bus.axi_req_hs[0] = 1'b0;
      bus.shutdown_req = 1'b1;
      repeat (2) tick();
      bus.shutdown_req = 1'b0;
      tick();
      check("abort_active", 32'(bus.active), 32'd1);
      check("abort_irq", 32'(bus.irq), 32'd0);
      bus.axi_rsp_hs[0] = 1'b1;
      tick();
      bus.axi_rsp_hs[0] = 1'b0;
      bus.shutdown_req = 1'b1;
      repeat (3) tick();
      check("halt_ack", 32'(bus.shutdown_ack), 32'd1);
      bus.shutdown_req = 1'b0;
      tick();
      check("resume_active", 32'(bus.active), 32'd1);
      check("resume_ack", 32'(bus.shutdown_ack), 32'd0);
      check("resume_decouple", 32'(bus.decouple), 32'd0);

      // counter saturation on master 0
      bus.axi_req_hs[0] = 1'b1;
      repeat (CNT_MAX_I) tick();
      bus.axi_req_hs[0] = 1'b0;
      check("sat_req_en0", 32'(bus.axi_req_en[0]), 32'd0);
      check("sat_req_en1", 32'(bus.axi_req_en[1]), 32'd1);
      bus.axi_rsp_hs[0] = 1'b1;
      tick();
      check("unsat_req_en0", 32'(bus.axi_req_en[0]), 32'd1);
      repeat (CNT_MAX_I - 1) tick();
      bus.axi_rsp_hs[0] = 1'b0;
      tick();

      // never-completing transaction on master 2
      bus.axi_req_hs[2] = 1'b1;
      tick();
      bus.axi_req_hs[2] = 1'b0;
      bus.shutdown_req = 1'b1;
      wait_ack(40, lat);
      if (TO_EN) begin
         check("timeout_lat", 32'(lat), 32'(T_MAX_I + 2));
         check("timeout_flag_set", 32'(bus.timeout_flag), 32'd1);
         check("timeout_irq", 32'(bus.irq), 32'd1);
      end else begin
         check("no_timeout_lat", 32'(lat), 32'hffff_ffff);
         check("no_timeout_active", 32'(bus.active), 32'd0);
      end
      // asynchronous reset while parked in DRAIN or HALTED
      #2;
      apply_reset();
      #1;
      check("async_rst_active", 32'(bus.active), 32'd1);
      check("async_rst_ack", 32'(bus.shutdown_ack), 32'd0);
      bus.shutdown_req = 1'b0;
      tick();
      rst_n = 1'b1;

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 999) == 0) apply_reset();
         if ($urandom_range(0, 39) == 0) bus.shutdown_req = !bus.shutdown_req;
         for (int i = 0; i < NUM_ETH; i++) begin
            bus.eth_tvalid[i] = m_txen(i) && ($urandom_range(0, 1) == 1);
            bus.eth_tready[i] = ($urandom_range(0, 3) != 0);
            bus.eth_tlast[i]  = ($urandom_range(0, 3) == 0);
         end
         for (int j = 0; j < NUM_AXI; j++) begin
            bus.axi_req_hs[j] = (m_cnt[j] < CNT_MAX_I) && (m_phase != P_HALT) &&
                                ($urandom_range(0, (m_phase == P_RUN) ? 2 : 9) == 0);
            bus.axi_rsp_hs[j] = ($urandom_range(0, 2) == 0);
         end
      end

      idle_inputs();
      bus.shutdown_req = 1'b0;
      rst_n = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      #1;
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
